// File: rtl/serial_frame_tx.sv
// serial_frame_tx: turns one parallel payload into a serial frame on a single line.
// A frame is the preamble 0,1,0, then DATA_W payload bits, then GAP idle '1' bits,
// and the line rests at '1' between frames. Completed frames are counted in
// frames_sent, which wraps silently.
module serial_frame_tx #(
    parameter int DATA_W    = 8,   // payload bits per frame (>= 2)
    parameter int GAP       = 1,   // idle '1' bits after the payload, 0..15
    parameter int CNT_W     = 10,  // width of frames_sent
    parameter bit MSB_FIRST = 1'b1 // 1: payload bit DATA_W-1 goes out first
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [CNT_W-1:0]  frames_sent
);

    localparam int CW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    // Bit counter value while the last payload bit is on the line, and the one before it.
    localparam logic [CW-1:0]    CNT_LAST = CW'(DATA_W - 1);
    localparam logic [CW-1:0]    CNT_PEN  = CW'(DATA_W - 2);
    localparam logic [CW-1:0]    CNT_ZERO = '0;
    localparam logic [CW-1:0]    CNT_ONE  = CW'(1);
    localparam logic [3:0]       GAP_LAST = (GAP == 0) ? 4'd0 : 4'(GAP - 1);
    localparam logic [CNT_W-1:0] FRM_ONE  = CNT_W'(1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PRE0 = 3'd1,
        S_PRE1 = 3'd2,
        S_PRE2 = 3'd3,
        S_DATA = 3'd4,
        S_GAP  = 3'd5
    } state_t;

    state_t             r_state;
    logic               r_tx;
    logic               r_frame_done;
    logic [DATA_W-1:0]  r_shift;
    logic [CW-1:0]      r_bit_cnt;
    logic [3:0]         r_gap_cnt;
    logic [CNT_W-1:0]   r_frames_sent;

    // Bit that goes on the line next, taken from the head of the shift register.
    function automatic logic head_bit(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? s[DATA_W-1] : s[0];
    endfunction

    // Shift register after its head bit has been consumed.
    function automatic logic [DATA_W-1:0] shift_out(input logic [DATA_W-1:0] s);
        return MSB_FIRST ? {s[DATA_W-2:0], 1'b0} : {1'b0, s[DATA_W-1:1]};
    endfunction

    // Frame sequencer: tx and frame_done are registered together with the state
    // so that the line value always belongs to the state it is shown in.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_tx          <= 1'b1;
            r_frame_done  <= 1'b0;
            r_shift       <= '0;
            r_bit_cnt     <= '0;
            r_gap_cnt     <= '0;
            r_frames_sent <= '0;
        end else begin
            r_frame_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_tx <= 1'b1;
                    if (in_valid) begin
                        r_shift <= in_data;
                        r_tx    <= 1'b0;
                        r_state <= S_PRE0;
                    end
                end
                S_PRE0: begin
                    r_tx    <= 1'b1;
                    r_state <= S_PRE1;
                end
                S_PRE1: begin
                    r_tx    <= 1'b0;
                    r_state <= S_PRE2;
                end
                S_PRE2: begin
                    r_tx         <= head_bit(r_shift);
                    r_shift      <= shift_out(r_shift);
                    r_bit_cnt    <= CNT_ZERO;
                    r_frame_done <= (DATA_W == 1);
                    r_state      <= S_DATA;
                end
                S_DATA: begin
                    if (r_bit_cnt == CNT_LAST) begin
                        // Last payload bit is on the line this cycle: the frame is complete.
                        r_frames_sent <= r_frames_sent + FRM_ONE;
                        r_tx          <= 1'b1;
                        r_bit_cnt     <= CNT_ZERO;
                        r_gap_cnt     <= 4'd0;
                        r_state       <= (GAP == 0) ? S_IDLE : S_GAP;
                    end else begin
                        r_tx         <= head_bit(r_shift);
                        r_shift      <= shift_out(r_shift);
                        r_bit_cnt    <= r_bit_cnt + CNT_ONE;
                        r_frame_done <= (r_bit_cnt == CNT_PEN);
                    end
                end
                S_GAP: begin
                    r_tx <= 1'b1;
                    if (r_gap_cnt == GAP_LAST) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_gap_cnt <= r_gap_cnt + 4'd1;
                    end
                end
                default: begin
                    r_tx    <= 1'b1;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign in_ready    = (r_state == S_IDLE);
    assign busy        = (r_state != S_IDLE);
    assign tx          = r_tx;
    assign frame_done  = r_frame_done;
    assign frames_sent = r_frames_sent;

endmodule
